decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Next-generation MIPS decode stage with an owned F/D pipeline register and valid/ready handshakes on both sides.
- Adds synchronous flush from branch resolution and a wider opcode set (ANDI/ORI zero-extend, LUI, BNE, J).
- Adds an illegal-opcode flag and load-use interlock detection.
- Sits between fetch and execute; register-file read data returns combinationally within the same cycle.

Parameters:
- PC_W, 32, width of pc_plus_4 and jump_target.
- DATA_W, 32, register-file data and extended-immediate width (≥16).
- REG_W, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  F/D register can accept.
- in_instr  in  32  instruction word.
- in_pc_plus_4  in  PC_W  PC+4 of the instruction.
- flush  in  1  discard held instruction (taken branch/jump).
- rs_addr, rt_addr  out  REG_W  register-file read addresses (from held instruction).
- rd1, rd2  in  DATA_W  register-file read data.
- out_valid  out  1  decoded instruction valid to execute.
- out_ready  in  1  execute accepts this cycle; also means E advances.
- out_rd1, out_rd2  out  DATA_W  pass-through of rd1/rd2.
- out_rs, out_rt, out_rd  out  REG_W  instr[25:21], [20:16], [15:11].
- out_imm  out  DATA_W  extended immediate.
- out_pc_plus_4  out  PC_W  held PC+4.
- out_jump_target  out  PC_W  {pc_plus_4[PC_W-1:28], instr[25:0], 2'b00}.
- out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_dst, out_branch, out_branch_ne, out_jump  out  1  controls.
- out_alu_op  out  6  func for R-type, else opcode.
- out_illegal  out  1  opcode not in supported set.
- stall_req  out  1  load-use interlock active.

Behaviour:
- Reset (async): d_valid=0, held instr=0, held pc=0, lw_e_valid=0, lw_e_rt=0.
  - Consequently out_valid=0, stall_req=0, and all controls decode from instr 0 (NOP) to 0.
- in_ready = !flush && (!d_valid || out_fire), where out_fire = out_valid && out_ready.
- Posedge, in priority order:
  - flush: d_valid<=0; the input is not captured.
  - in_valid && in_ready: capture instr and pc, d_valid<=1.
  - out_fire: d_valid<=0.
  - otherwise: hold.
- Outputs are combinational from the held register; decode latency is 0 cycles after capture.
- Controls are forced to 0 when !d_valid; out_alu_op and fields remain raw.
- Supported opcodes: 00 R, 02 J, 04 BEQ, 05 BNE, 08 ADDI, 09 ADDIU, 0C ANDI, 0D ORI, 0F LUI, 23 LW, 2B SW.
- Immediate extension:
  - Sign-extend for ADDI, ADDIU, LW, SW, BEQ, BNE.
  - Zero-extend for ANDI, ORI.
  - LUI: {imm16, 16'b0}, zero-extended to DATA_W.
- Control decode:
  - reg_write for R with instr≠0, ADDI, ADDIU, ANDI, ORI, LUI, LW.
  - reg_dst = R.
  - alu_src for I-type ALU ops, LW, SW.
  - mem_to_reg = LW; mem_write = SW.
  - branch = BEQ|BNE; branch_ne = BNE; jump = J.
- Illegal opcode: all controls 0, out_illegal=1 while d_valid; the instruction still flows (fires) as a bubble.
- Load-use tracking. E-stage tracker updates only when out_ready=1:
  - lw_e_valid <= out_fire && LW && rt≠0.
  - lw_e_rt <= rt.
  - When out_ready=0 the tracker holds.
- hazard = d_valid && lw_e_valid && (rs==lw_e_rt || (uses_rt && rt==lw_e_rt)).
  - uses_rt = R, BEQ, BNE, SW.
- hazard forces out_valid=0 and stall_req=1; the F/D register holds.
- Boundary cases:
  - A hazard lasts exactly one cycle when out_ready=1, and persists while out_ready=0.
  - flush also clears the hazard in the same cycle, since d_valid drops.
  - flush does not alter the tracker.
  - Reset mid-stall: all state cleared immediately, no cycle needed.

Optional Feature:
- Macro DECODE_LOAD_USE_INTERLOCK_EN.
- Defined: interlock tracker and stall_req behave as above.
- Undefined: no tracker flops; hazard is constant 0 and stall_req is tied to 0, so software or a forwarding unit must handle load-use.

Test Plan:
- Reset asserted mid-transfer, then released -> out_valid=0, in_ready=1, all controls 0; first instr 0x2008FFFF (ADDI $8,$0,-1) next cycle -> out_imm=0xFFFFFFFF, reg_write=1, alu_src=1, alu_op=0x08.
- ORI 0x3508F000 -> out_imm=0x0000F000; LUI 0x3C081234 -> out_imm=0x12340000.
- J 0x08000010 with pc_plus_4=0x40000004 -> out_jump=1, out_jump_target=0x40000040.
- LW $9,0($8) fires, then ADD $10,$9,$9 with out_ready=1 -> one cycle stall_req=1/out_valid=0, ADD fires on the following cycle.
  - Repeat with out_ready=0 for 3 cycles -> stall persists all 3 cycles.
  - With the macro off -> no stall.
- flush asserted together with in_valid=1 while holding a BEQ -> BEQ discarded, new instruction not captured, out_valid=0 next cycle.
- out_ready=0 for 4 cycles while holding SW -> outputs stable, in_ready=0; opcode 0x3F -> out_illegal=1, all controls 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side and register-file signals of the decode stage.
// The decode stage connects through the slave modport; its environment uses master.
interface decode_stage_if #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc_plus_4;
   logic              flush;
   logic [REG_W-1:0]  rs_addr;
   logic [REG_W-1:0]  rt_addr;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_rd1;
   logic [DATA_W-1:0] out_rd2;
   logic [REG_W-1:0]  out_rs;
   logic [REG_W-1:0]  out_rt;
   logic [REG_W-1:0]  out_rd;
   logic [DATA_W-1:0] out_imm;
   logic [PC_W-1:0]   out_pc_plus_4;
   logic [PC_W-1:0]   out_jump_target;
   logic              out_reg_write;
   logic              out_mem_to_reg;
   logic              out_mem_write;
   logic              out_alu_src;
   logic              out_reg_dst;
   logic              out_branch;
   logic              out_branch_ne;
   logic              out_jump;
   logic [5:0]        out_alu_op;
   logic              out_illegal;
   logic              stall_req;

   modport slave (
      input  in_valid, in_instr, in_pc_plus_4, flush, rd1, rd2, out_ready,
      output in_ready, rs_addr, rt_addr, out_valid, out_rd1, out_rd2,
             out_rs, out_rt, out_rd, out_imm, out_pc_plus_4, out_jump_target,
             out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src,
             out_reg_dst, out_branch, out_branch_ne, out_jump, out_alu_op,
             out_illegal, stall_req
   );

   modport master (
      output in_valid, in_instr, in_pc_plus_4, flush, rd1, rd2, out_ready,
      input  in_ready, rs_addr, rt_addr, out_valid, out_rd1, out_rd2,
             out_rs, out_rt, out_rd, out_imm, out_pc_plus_4, out_jump_target,
             out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src,
             out_reg_dst, out_branch, out_branch_ne, out_jump, out_alu_op,
             out_illegal, stall_req
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage owning the F/D register, with flush, illegal-opcode flag and
// an optional load-use interlock enabled by the DECODE_LOAD_USE_INTERLOCK_EN macro.
module decode_stage #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);
   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic              d_valid_q, d_valid_d;
   logic [31:0]       instr_q, instr_d;
   logic [PC_W-1:0]   pc_q, pc_d;

   logic [5:0]        opcode_s;
   logic [5:0]        funct_s;
   logic [15:0]       imm16_s;
   logic [REG_W-1:0]  rs_s, rt_s, rd_s;
   logic [DATA_W-1:0] imm_s;
   logic              reg_write_s, mem_to_reg_s, mem_write_s, alu_src_s;
   logic              reg_dst_s, branch_s, branch_ne_s, jump_s, illegal_s;
   logic              hazard_s, out_valid_s, out_fire_s, in_ready_s;

   assign opcode_s = instr_q[31:26];
   assign funct_s  = instr_q[5:0];
   assign imm16_s  = instr_q[15:0];
   assign rs_s     = REG_W'(instr_q[25:21]);
   assign rt_s     = REG_W'(instr_q[20:16]);
   assign rd_s     = REG_W'(instr_q[15:11]);

   // Raw control and immediate decode of the held instruction.
   always_comb begin
      reg_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      mem_write_s  = 1'b0;
      alu_src_s    = 1'b0;
      reg_dst_s    = 1'b0;
      branch_s     = 1'b0;
      branch_ne_s  = 1'b0;
      jump_s       = 1'b0;
      illegal_s    = 1'b0;
      imm_s        = DATA_W'($signed(imm16_s));
      case (opcode_s)
         OP_R: begin
            reg_dst_s   = 1'b1;
            reg_write_s = (instr_q != 32'h0000_0000);
         end
         OP_J:   jump_s = 1'b1;
         OP_BEQ: branch_s = 1'b1;
         OP_BNE: begin
            branch_s    = 1'b1;
            branch_ne_s = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
         end
         OP_ANDI, OP_ORI: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            imm_s       = DATA_W'(imm16_s);
         end
         OP_LUI: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            imm_s       = DATA_W'({imm16_s, 16'h0000});
         end
         OP_LW: begin
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            mem_to_reg_s = 1'b1;
         end
         OP_SW: begin
            alu_src_s   = 1'b1;
            mem_write_s = 1'b1;
         end
         default: illegal_s = 1'b1;
      endcase
   end

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
   // Tracks a load that has moved into execute so a dependent consumer waits one cycle.
   logic             lw_e_valid_q, lw_e_valid_d;
   logic [REG_W-1:0] lw_e_rt_q, lw_e_rt_d;
   logic             uses_rt_s;

   assign uses_rt_s = (opcode_s == OP_R) || (opcode_s == OP_BEQ) ||
                      (opcode_s == OP_BNE) || (opcode_s == OP_SW);
   assign hazard_s  = d_valid_q && lw_e_valid_q &&
                      ((rs_s == lw_e_rt_q) || (uses_rt_s && (rt_s == lw_e_rt_q)));

   // Execute-stage load tracker advances only when execute advances.
   always_comb begin
      lw_e_valid_d = lw_e_valid_q;
      lw_e_rt_d    = lw_e_rt_q;
      if (bus.out_ready) begin
         lw_e_valid_d = out_fire_s && (opcode_s == OP_LW) && (rt_s != '0);
         lw_e_rt_d    = rt_s;
      end else begin
         lw_e_valid_d = lw_e_valid_q;
         lw_e_rt_d    = lw_e_rt_q;
      end
   end

   // Tracker register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lw_e_valid_q <= 1'b0;
         lw_e_rt_q    <= '0;
      end else begin
         lw_e_valid_q <= lw_e_valid_d;
         lw_e_rt_q    <= lw_e_rt_d;
      end
   end
`else
   assign hazard_s = 1'b0;
`endif

   assign out_valid_s = d_valid_q && !hazard_s;
   assign out_fire_s  = out_valid_s && bus.out_ready;
   assign in_ready_s  = !bus.flush && (!d_valid_q || out_fire_s);

   // F/D register next state: flush beats capture, capture beats drain.
   always_comb begin
      d_valid_d = d_valid_q;
      instr_d   = instr_q;
      pc_d      = pc_q;
      if (bus.flush) begin
         d_valid_d = 1'b0;
      end else if (bus.in_valid && in_ready_s) begin
         d_valid_d = 1'b1;
         instr_d   = bus.in_instr;
         pc_d      = bus.in_pc_plus_4;
      end else if (out_fire_s) begin
         d_valid_d = 1'b0;
      end else begin
         d_valid_d = d_valid_q;
      end
   end

   // F/D register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_valid_q <= 1'b0;
         instr_q   <= 32'h0000_0000;
         pc_q      <= '0;
      end else begin
         d_valid_q <= d_valid_d;
         instr_q   <= instr_d;
         pc_q      <= pc_d;
      end
   end

   assign bus.in_ready        = in_ready_s;
   assign bus.rs_addr         = rs_s;
   assign bus.rt_addr         = rt_s;
   assign bus.out_valid       = out_valid_s;
   assign bus.stall_req       = hazard_s;
   assign bus.out_rd1         = bus.rd1;
   assign bus.out_rd2         = bus.rd2;
   assign bus.out_rs          = rs_s;
   assign bus.out_rt          = rt_s;
   assign bus.out_rd          = rd_s;
   assign bus.out_imm         = imm_s;
   assign bus.out_pc_plus_4   = pc_q;
   assign bus.out_jump_target = {pc_q[PC_W-1:28], instr_q[25:0], 2'b00};
   assign bus.out_alu_op      = (opcode_s == OP_R) ? funct_s : opcode_s;
   // Controls are qualified by d_valid; fields and alu_op stay raw.
   assign bus.out_reg_write   = d_valid_q && reg_write_s;
   assign bus.out_mem_to_reg  = d_valid_q && mem_to_reg_s;
   assign bus.out_mem_write   = d_valid_q && mem_write_s;
   assign bus.out_alu_src     = d_valid_q && alu_src_s;
   assign bus.out_reg_dst     = d_valid_q && reg_dst_s;
   assign bus.out_branch      = d_valid_q && branch_s;
   assign bus.out_branch_ne   = d_valid_q && branch_ne_s;
   assign bus.out_jump        = d_valid_q && jump_s;
   assign bus.out_illegal     = d_valid_q && illegal_s;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decodes are queued at capture and
// compared when execute accepts; directed checks cover reset, stalls and flush.
module tb_decode_stage;
   localparam int PC_W   = 32;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
   localparam bit IL = 1'b1;
`else
   localparam bit IL = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      bit          imm_chk;
      logic [7:0]  ctrl;
      logic [5:0]  alu_op;
      logic        illegal;
      logic [31:0] jt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   last_push;
   exp_t sb_q[$];

   decode_stage_if #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();
   decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   assign bus.rd1 = 32'hA5A5_0000 | {27'd0, bus.rs_addr};
   assign bus.rd2 = 32'h5A5A_0000 | {27'd0, bus.rt_addr};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctrl_obs();
      return {bus.out_reg_write, bus.out_mem_to_reg, bus.out_mem_write, bus.out_alu_src,
              bus.out_reg_dst, bus.out_branch, bus.out_branch_ne, bus.out_jump};
   endfunction

   // Reference decode; ctrl bits are {rw, m2r, mw, asrc, rdst, br, bne, jmp}.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      logic [15:0] im = ins[15:0];
      e.instr = ins; e.pc = pc; e.illegal = 1'b0; e.imm_chk = 1'b1;
      e.imm = {{16{im[15]}}, im};
      e.alu_op = ins[31:26];
      e.jt = {pc[31:28], ins[25:0], 2'b00};
      case (ins[31:26])
         6'h00: begin e.ctrl = (ins != 32'd0) ? 8'b1000_1000 : 8'b0000_1000;
                      e.alu_op = ins[5:0]; e.imm_chk = 1'b0; end
         6'h02: begin e.ctrl = 8'b0000_0001; e.imm_chk = 1'b0; end
         6'h04: e.ctrl = 8'b0000_0100;
         6'h05: e.ctrl = 8'b0000_0110;
         6'h08, 6'h09: e.ctrl = 8'b1001_0000;
         6'h0C, 6'h0D: begin e.ctrl = 8'b1001_0000; e.imm = {16'h0000, im}; end
         6'h0F: begin e.ctrl = 8'b1001_0000; e.imm = {im, 16'h0000}; end
         6'h23: e.ctrl = 8'b1101_0000;
         6'h2B: e.ctrl = 8'b0011_0000;
         default: begin e.ctrl = 8'b0000_0000; e.illegal = 1'b1; e.imm_chk = 1'b0; end
      endcase
      return e;
   endfunction

   // One cycle: compare on fire at negedge, record captures, return at posedge+1.
   task automatic step();
      exp_t e;
      @(negedge clk);
      last_push = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_fire", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq("ctrl", {56'd0, ctrl_obs()}, {56'd0, e.ctrl});
            check_eq("illegal", {63'd0, bus.out_illegal}, {63'd0, e.illegal});
            check_eq("alu_op", {58'd0, bus.out_alu_op}, {58'd0, e.alu_op});
            if (e.imm_chk) check_eq("imm", {32'd0, bus.out_imm}, {32'd0, e.imm});
            check_eq("fields", {49'd0, bus.out_rs, bus.out_rt, bus.out_rd},
                     {49'd0, e.instr[25:21], e.instr[20:16], e.instr[15:11]});
            check_eq("rd1_rd2", {bus.out_rd1, bus.out_rd2},
                     {32'hA5A5_0000 | {27'd0, e.instr[25:21]},
                      32'h5A5A_0000 | {27'd0, e.instr[20:16]}});
            check_eq("pc_jt", {bus.out_pc_plus_4, bus.out_jump_target}, {e.pc, e.jt});
         end
      end
      if (reset || bus.flush) begin
         sb_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
         sb_q.push_back(model(bus.in_instr, bus.in_pc_plus_4));
         last_push = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      int n = 0;
      bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc_plus_4 = pc;
      step();
      while (!last_push && n < 50) begin
         bus.out_ready = 1'b1;
         step();
         n++;
      end
      if (!last_push) check_eq("send_timeout", 64'd1, 64'd0);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (sb_q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic [5:0]  ops [12] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                                6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc_plus_4 = 32'd0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset asserted while an instruction is held, then released.
      send(32'h0129_5020, 32'h0000_0100);
      check_eq("held_before_reset", {63'd0, bus.out_valid}, 64'd1);
      reset = 1'b1;
      #1 check_eq("async_reset_valid", {63'd0, bus.out_valid}, 64'd0);
      step();
      reset = 1'b0;
      #1;
      check_eq("rst_valid_ready", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
      check_eq("rst_ctrl", {54'd0, ctrl_obs(), bus.out_illegal, bus.stall_req}, 64'd0);

      // ADDI $8,$0,-1 held with execute not ready.
      send(32'h2008_FFFF, 32'h0000_0104);
      check_eq("addi_imm", {32'd0, bus.out_imm}, 64'h0000_0000_FFFF_FFFF);
      check_eq("addi_ctrl", {56'd0, ctrl_obs()}, 64'h90);
      check_eq("addi_aluop", {58'd0, bus.out_alu_op}, 64'h08);
      bus.out_ready = 1'b1;
      send(32'h3508_F000, 32'h0000_0108);
      check_eq("ori_imm", {32'd0, bus.out_imm}, 64'h0000_F000);
      send(32'h3C08_1234, 32'h0000_010C);
      check_eq("lui_imm", {32'd0, bus.out_imm}, 64'h1234_0000);
      send(32'h0800_0010, 32'h4000_0004);
      check_eq("j_jump", {63'd0, bus.out_jump}, 64'd1);
      check_eq("j_target", {32'd0, bus.out_jump_target}, 64'h4000_0040);

      // Load-use: LW $9,0($8) then ADD $10,$9,$9 with execute ready.
      send(32'h8D09_0000, 32'h0000_0200);
      send(32'h0129_5020, 32'h0000_0204);
      check_eq("lu_stall", {62'd0, bus.stall_req, bus.out_valid}, {62'd0, IL, !IL});
      step();
      check_eq("lu_after", {62'd0, bus.stall_req, bus.out_valid}, {62'd0, 1'b0, IL});
      drain();

      // Load-use with execute stalled for three cycles.
      send(32'h8D09_0000, 32'h0000_0300);
      send(32'h0129_5020, 32'h0000_0304);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("lu_hold_stall", {62'd0, bus.stall_req, bus.out_valid}, {62'd0, IL, !IL});
         step();
      end
      bus.out_ready = 1'b1;
      #1 check_eq("lu_release", {63'd0, bus.stall_req}, {63'd0, IL});
      drain();

      // Flush with a new offer while holding BEQ.
      bus.out_ready = 1'b0;
      send(32'h1109_0003, 32'h0000_0400);
      check_eq("beq_ctrl", {56'd0, ctrl_obs()}, 64'h04);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h2008_0001;
      #1 check_eq("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      #1 check_eq("flush_valid", {63'd0, bus.out_valid}, 64'd0);

      // SW held for four cycles while an illegal opcode waits at the input.
      send(32'hAD09_0004, 32'h0000_0500);
      bus.in_valid = 1'b1; bus.in_instr = 32'hFC00_0000; bus.in_pc_plus_4 = 32'h0000_0504;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("sw_hold", {bus.out_imm, 24'd0, ctrl_obs(), bus.in_ready, bus.out_valid},
                  {32'h0000_0004, 24'd0, 8'h30, 1'b0, 1'b1});
         step();
      end
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      #1;
      check_eq("illegal_flag", {55'd0, bus.out_illegal, ctrl_obs()}, {55'd0, 1'b1, 8'h00});
      drain();

      // Random stream with random execute back-pressure.
      for (int i = 0; i < 40; i++) begin
         r = $urandom();
         bus.out_ready = 1'($urandom_range(0, 1));
         send({ops[$urandom_range(0, 11)], r[25:0]}, $urandom());
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
